// File: rtl/udp_rx_parser_pkg.sv
// Shared constants, FSM state type and big-endian field helpers for the UDP receive parser.
// Byte offsets are absolute positions in the Ethernet frame. The helpers reduce them to a
// byte lane of the current 64-bit beat.
package udp_rx_parser_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  localparam logic [47:0] MAC_ADDR  = 48'h1A1B1C1D1E1F;
  localparam logic [47:0] BCAST_MAC = 48'hFFFFFFFFFFFF;
  localparam logic [15:0] LT        = 16'h0800;

  localparam int unsigned HDR_LEN   = 42;
  // Whole header beats; the last two header bytes spill into the first payload beat.
  localparam int unsigned HDR_BEATS = HDR_LEN / KEEP_WIDTH;

  localparam logic [7:0] IPV4_VER_IHL = 8'h45;
  localparam logic [7:0] IP_PROTO_UDP = 8'h11;

  localparam int unsigned OFF_DST_MAC  = 0;
  localparam int unsigned OFF_ETYPE    = 12;
  localparam int unsigned OFF_VER_IHL  = 14;
  localparam int unsigned OFF_PROTO    = 23;
  localparam int unsigned OFF_SRC_IP   = 26;
  localparam int unsigned OFF_DST_IP   = 30;
  localparam int unsigned OFF_SRC_PORT = 34;
  localparam int unsigned OFF_DST_PORT = 36;

  typedef enum logic [1:0] {
    StHdr,
    StPayload,
    StFlush,
    StDrop
  } state_e;

  // Byte at absolute frame offset 'off' taken from the beat that carries it.
  function automatic logic [7:0] get_byte(input logic [DATA_WIDTH-1:0] data,
                                          input int unsigned off);
    return 8'(data >> (8 * (off % KEEP_WIDTH)));
  endfunction

  function automatic logic [15:0] be16(input logic [DATA_WIDTH-1:0] data,
                                       input int unsigned off);
    return {get_byte(data, off), get_byte(data, off + 1)};
  endfunction

  function automatic logic [31:0] be32(input logic [DATA_WIDTH-1:0] data,
                                       input int unsigned off);
    return {be16(data, off), be16(data, off + 2)};
  endfunction

  function automatic logic [47:0] be48(input logic [DATA_WIDTH-1:0] data,
                                       input int unsigned off);
    return {be16(data, off), be32(data, off + 2)};
  endfunction

endpackage

// File: rtl/udp_rx_parser_if.sv
// 64-bit AXI-Stream bundle.
//   master: drives tdata/tkeep/tvalid/tlast, samples tready
//   slave : samples tdata/tkeep/tvalid/tlast, drives tready
interface udp_rx_parser_if;
  import udp_rx_parser_pkg::*;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/udp_rx_parser_axis_realign_2b.sv
// Payload realignment datapath: the payload starts at byte lane 2 of the input, so six bytes
// are held over from each beat and joined with the first two bytes of the next one.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   in_data_i/in_keep_i/in_last_i  current accepted input beat
//   hold_load_i            capture input lanes 2..7 into the holdover register
//   emit_i                 load output with {input lanes 0..1, holdover}
//   flush_i                load output with the remaining holdover bytes as the last beat
//   m_tready_i             downstream ready
//   m_t*_o                 registered output stage
//   out_free_o             output stage can accept a new beat this cycle
module udp_rx_parser_axis_realign_2b
  import udp_rx_parser_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [KEEP_WIDTH-1:0] in_keep_i,
  input  logic                  in_last_i,
  input  logic                  hold_load_i,
  input  logic                  emit_i,
  input  logic                  flush_i,
  input  logic                  m_tready_i,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic [KEEP_WIDTH-1:0] m_tkeep_o,
  output logic                  m_tvalid_o,
  output logic                  m_tlast_o,
  output logic                  out_free_o
);

  localparam int unsigned HoldW = DATA_WIDTH - 16;
  localparam int unsigned HoldK = KEEP_WIDTH - 2;

  logic [HoldW-1:0]      hold_q, hold_d;
  logic [HoldK-1:0]      hold_keep_q, hold_keep_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [KEEP_WIDTH-1:0] keep_q, keep_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;

  assign out_free_o = ~valid_q | m_tready_i;

  always_comb begin
    hold_d      = hold_q;
    hold_keep_d = hold_keep_q;
    data_d      = data_q;
    keep_d      = keep_q;
    last_d      = last_q;
    valid_d     = valid_q & ~m_tready_i;

    if (hold_load_i) begin
      hold_d      = in_data_i[DATA_WIDTH-1:16];
      hold_keep_d = in_keep_i[KEEP_WIDTH-1:2];
    end

    if (emit_i) begin
      data_d  = {in_data_i[15:0], hold_q};
      keep_d  = {in_keep_i[1:0], {HoldK{1'b1}}};
      // Input lanes 2+ valid on the last beat means bytes remain for a flush beat.
      last_d  = in_last_i & ~in_keep_i[2];
      valid_d = 1'b1;
    end else if (flush_i) begin
      data_d  = {16'h0000, hold_q};
      keep_d  = {2'b00, hold_keep_q};
      last_d  = 1'b1;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q      <= '0;
      hold_keep_q <= '0;
      data_q      <= '0;
      keep_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_keep_q <= hold_keep_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  assign m_tdata_o  = data_q;
  assign m_tkeep_o  = keep_q;
  assign m_tvalid_o = valid_q;
  assign m_tlast_o  = last_q;

endmodule

// File: rtl/udp_rx_parser.sv
// Ethernet/IPv4/UDP receive parser. Checks the header of each 64-bit AXI-Stream frame,
// strips the 42-byte header and forwards the realigned UDP payload; counts passed/dropped frames.
// Ports:
//   clk_i, s_rst_n_i       clock, async active-low reset
//   en_i                   frame enable, sampled on the first header beat
//   dst_ipv4_addr_i        required destination IPv4 address
//   dst_udp_port_i         required destination UDP port
//   s_axis                 frame input (slave)
//   m_axis                 payload output (master)
//   src_ipv4_addr_o        source IPv4 of the last accepted frame
//   src_udp_port_o         source UDP port of the last accepted frame
//   pass_cnt_o/drop_cnt_o  frame counters, wrapping
module udp_rx_parser
  import udp_rx_parser_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  s_rst_n_i,
  input  logic                  en_i,
  input  logic [31:0]           dst_ipv4_addr_i,
  input  logic [15:0]           dst_udp_port_i,
  udp_rx_parser_if.slave        s_axis,
  udp_rx_parser_if.master       m_axis,
  output logic [31:0]           src_ipv4_addr_o,
  output logic [15:0]           src_udp_port_o,
  output logic [31:0]           pass_cnt_o,
  output logic [31:0]           drop_cnt_o
);

  localparam logic [2:0] LastHdrBeat = 3'(HDR_BEATS - 1);

  state_e      state_q, state_d;
  logic [2:0]  beat_cnt_q, beat_cnt_d;
  logic        hdr_ok_q, hdr_ok_d;
  logic        en_q, en_d;
  logic        rdy_q;
  logic [31:0] sip_sh_q, sip_sh_d;
  logic [15:0] sport_sh_q, sport_sh_d;
  logic        first_q, first_d;
  logic        m_first_q, m_first_d;
  logic [31:0] m_sip_q, m_sip_d;
  logic [15:0] m_sport_q, m_sport_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [15:0] src_port_q, src_port_d;
  logic [31:0] pass_q, pass_d;
  logic [31:0] drop_q, drop_d;

  logic                  s_tready, s_fire, m_fire, out_free, beat_ok;
  logic                  hold_load, emit, flush;
  logic [DATA_WIDTH-1:0] d;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic [KEEP_WIDTH-1:0] m_tkeep;
  logic                  m_tvalid, m_tlast;

  assign d        = s_axis.tdata;
  // rdy_q keeps tready low for the first cycle after reset release.
  assign s_tready = rdy_q & (state_q != StFlush) & ((state_q != StPayload) | out_free);
  assign s_fire   = s_axis.tvalid & s_tready;
  assign m_fire   = m_tvalid & m_axis.tready;

  // Header check for the beat currently presented.
  always_comb begin
    beat_ok = 1'b0;
    case (beat_cnt_q)
      3'd0: beat_ok = (be48(d, OFF_DST_MAC) == MAC_ADDR) || (be48(d, OFF_DST_MAC) == BCAST_MAC);
      3'd1: beat_ok = (be16(d, OFF_ETYPE) == LT) && (get_byte(d, OFF_VER_IHL) == IPV4_VER_IHL);
      3'd2: beat_ok = get_byte(d, OFF_PROTO) == IP_PROTO_UDP;
      3'd3: beat_ok = be16(d, OFF_DST_IP) == dst_ipv4_addr_i[31:16];
      3'd4: beat_ok = (be16(d, OFF_DST_IP + 2) == dst_ipv4_addr_i[15:0]) &&
                      (be16(d, OFF_DST_PORT) == dst_udp_port_i);
      default: beat_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    hdr_ok_d   = hdr_ok_q;
    en_d       = en_q;
    sip_sh_d   = sip_sh_q;
    sport_sh_d = sport_sh_q;
    first_d    = first_q;
    m_first_d  = m_first_q;
    m_sip_d    = m_sip_q;
    m_sport_d  = m_sport_q;
    src_ip_d   = src_ip_q;
    src_port_d = src_port_q;
    pass_d     = pass_q;
    drop_d     = drop_q;
    hold_load  = 1'b0;
    emit       = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      StHdr: begin
        if (s_fire) begin
          hdr_ok_d = ((beat_cnt_q == 3'd0) | hdr_ok_q) & beat_ok;
          if (beat_cnt_q == 3'd0) en_d = en_i;
          if (beat_cnt_q == 3'd3) sip_sh_d = be32(d, OFF_SRC_IP);
          if (beat_cnt_q == 3'd4) sport_sh_d = be16(d, OFF_SRC_PORT);
          if (s_axis.tlast) begin
            drop_d     = drop_q + 32'd1;
            beat_cnt_d = 3'd0;
          end else if (beat_cnt_q == LastHdrBeat) begin
            beat_cnt_d = 3'd0;
            first_d    = 1'b1;
            state_d    = (hdr_ok_d & en_q) ? StPayload : StDrop;
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
          end
        end
      end
      StPayload: begin
        // beat_cnt 0 marks the first payload beat: it only primes the holdover.
        if (s_fire) begin
          hold_load  = 1'b1;
          emit       = (beat_cnt_q != 3'd0);
          beat_cnt_d = 3'd1;
          if (s_axis.tlast) begin
            beat_cnt_d = 3'd0;
            if (s_axis.tkeep[2]) begin
              state_d = StFlush;
            end else begin
              state_d = StHdr;
              if (beat_cnt_q == 3'd0) drop_d = drop_q + 32'd1;
            end
          end
        end
      end
      StFlush: begin
        if (out_free) begin
          flush   = 1'b1;
          state_d = StHdr;
        end
      end
      StDrop: begin
        if (s_fire && s_axis.tlast) begin
          drop_d  = drop_q + 32'd1;
          state_d = StHdr;
        end
      end
      default: state_d = StHdr;
    endcase

    // Source fields travel with the first output beat so a stalled beat keeps its own frame's
    // values even while the next header is already being parsed.
    if (emit || flush) begin
      m_first_d = first_q;
      m_sip_d   = sip_sh_q;
      m_sport_d = sport_sh_q;
      first_d   = 1'b0;
    end
    if (m_fire && m_first_q) begin
      src_ip_d   = m_sip_q;
      src_port_d = m_sport_q;
    end
    if (m_fire && m_tlast) pass_d = pass_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge s_rst_n_i) begin
    if (!s_rst_n_i) begin
      state_q    <= StHdr;
      beat_cnt_q <= '0;
      hdr_ok_q   <= 1'b0;
      en_q       <= 1'b0;
      rdy_q      <= 1'b0;
      sip_sh_q   <= '0;
      sport_sh_q <= '0;
      first_q    <= 1'b0;
      m_first_q  <= 1'b0;
      m_sip_q    <= '0;
      m_sport_q  <= '0;
      src_ip_q   <= '0;
      src_port_q <= '0;
      pass_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      hdr_ok_q   <= hdr_ok_d;
      en_q       <= en_d;
      rdy_q      <= 1'b1;
      sip_sh_q   <= sip_sh_d;
      sport_sh_q <= sport_sh_d;
      first_q    <= first_d;
      m_first_q  <= m_first_d;
      m_sip_q    <= m_sip_d;
      m_sport_q  <= m_sport_d;
      src_ip_q   <= src_ip_d;
      src_port_q <= src_port_d;
      pass_q     <= pass_d;
      drop_q     <= drop_d;
    end
  end

  udp_rx_parser_axis_realign_2b u_realign (
    .clk_i       (clk_i),
    .rst_ni      (s_rst_n_i),
    .in_data_i   (s_axis.tdata),
    .in_keep_i   (s_axis.tkeep),
    .in_last_i   (s_axis.tlast),
    .hold_load_i (hold_load),
    .emit_i      (emit),
    .flush_i     (flush),
    .m_tready_i  (m_axis.tready),
    .m_tdata_o   (m_tdata),
    .m_tkeep_o   (m_tkeep),
    .m_tvalid_o  (m_tvalid),
    .m_tlast_o   (m_tlast),
    .out_free_o  (out_free)
  );

  assign s_axis.tready   = s_tready;
  assign m_axis.tdata    = m_tdata;
  assign m_axis.tkeep    = m_tkeep;
  assign m_axis.tvalid   = m_tvalid;
  assign m_axis.tlast    = m_tlast;
  assign src_ipv4_addr_o = src_ip_q;
  assign src_udp_port_o  = src_port_q;
  assign pass_cnt_o      = pass_q;
  assign drop_cnt_o      = drop_q;

endmodule
